// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver: shadow registers, prescaled digit scan,
// per-digit decimal points, optional hex glyphs, leading-zero and inter-digit blanking.
module seg_scan_mux #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 1,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          load,
    input  logic [4*N_DIGITS-1:0]                         digits_in,
    input  logic [N_DIGITS-1:0]                           dp_in,
    input  logic                                          lz_en,
    output logic [N_DIGITS-1:0]                           an,
    output logic [6:0]                                    seg,
    output logic                                          dp,
    output logic [(N_DIGITS > 1 ? $clog2(N_DIGITS) : 1)-1:0] digit_idx,
    output logic                                          frame_tick
);

    localparam int          IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int          P_W     = $clog2(SCAN_DIV);
    localparam int unsigned LIT_CYC = SCAN_DIV - BLANK_CYC;
    localparam logic [IDX_W-1:0] K_MAX = IDX_W'(N_DIGITS - 1);
    localparam logic [P_W-1:0]   P_MAX = P_W'(SCAN_DIV - 1);
    localparam logic        INV     = (ACTIVE_LOW != 0);

    logic [4*N_DIGITS-1:0] shadow_digits;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  shadow_lz;
    logic [P_W-1:0]        p;
    logic [IDX_W-1:0]      k;

    logic                  lit;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [N_DIGITS-1:0]   an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            4'd10:   g = (HEX_MODE != 0) ? 7'h77 : 7'h00;
            4'd11:   g = (HEX_MODE != 0) ? 7'h7C : 7'h00;
            4'd12:   g = (HEX_MODE != 0) ? 7'h39 : 7'h00;
            4'd13:   g = (HEX_MODE != 0) ? 7'h5E : 7'h00;
            4'd14:   g = (HEX_MODE != 0) ? 7'h79 : 7'h00;
            default: g = (HEX_MODE != 0) ? 7'h71 : 7'h00;
        endcase
        return g;
    endfunction

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_n      = '0;
        lit       = (32'(p) < LIT_CYC);
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            if (IDX_W'(j) == k) begin
                cur_code  = shadow_digits[4*j +: 4];
                cur_dp    = shadow_dp[j];
                cur_blank = shadow_lz && (j != 0) && ((shadow_digits >> (4*j)) == '0);
                an_n[j]   = lit;
            end
        end
        seg_n = (lit && !cur_blank) ? decode(cur_code) : '0;
        dp_n  = lit && cur_dp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_lz     <= 1'b0;
            p             <= '0;
            k             <= '0;
            an            <= {N_DIGITS{INV}};
            seg           <= {7{INV}};
            dp            <= INV;
            digit_idx     <= '0;
            frame_tick    <= 1'b0;
        end else begin
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
                shadow_lz     <= lz_en;
            end
            if (p == P_MAX) begin
                p <= '0;
                k <= (k == K_MAX) ? '0 : k + 1'b1;
            end else begin
                p <= p + 1'b1;
            end
            an         <= an_n ^ {N_DIGITS{INV}};
            seg        <= seg_n ^ {7{INV}};
            dp         <= dp_n ^ INV;
            digit_idx  <= k;
            frame_tick <= (p == P_MAX) && (k == K_MAX);
        end
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Parametrised, time-multiplexed multi-digit 7-segment display driver. It builds on the single-digit BCD decoder by adding:
- a shadow register with load strobe
- a prescaled digit-scan counter
- per-digit decimal points
- optional hex glyphs
- leading-zero blanking
- an inter-digit blanking interval to suppress ghosting

It sits between the BCD/counter datapath and the board's common-anode display pins.

Parameters:
- N_DIGITS, 4: number of multiplexed digits; legal range 1..8.
- SCAN_DIV, 1000: clk cycles per digit slot; must be >= 2.
- BLANK_CYC, 1: cycles at the end of each slot with all anodes off; legal range 0..SCAN_DIV-1.
- HEX_MODE, 0: 1 means codes 10-15 show A,b,C,d,E,F; 0 means codes 10-15 are blank.
- ACTIVE_LOW, 1: 1 means seg/dp/an are driven active-low; 0 means active-high.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- load  in  1  single-cycle strobe; captures digits_in, dp_in, lz_en into the shadow registers
- digits_in  in  4*N_DIGITS  digit i occupies bits [4i+3:4i]; digit 0 is least significant/rightmost
- dp_in  in  N_DIGITS  decimal point per digit
- lz_en  in  1  leading-zero blanking enable
- an  out  N_DIGITS  digit enables, one-hot when active
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point of the currently scanned digit
- digit_idx  out  $clog2(N_DIGITS) (min 1)  index of the currently scanned digit
- frame_tick  out  1  one-cycle pulse at the end of each full scan

Behaviour:
Reset (rst_n=0 at a clk edge, synchronous only):
- shadow digits/dp/lz_en cleared to 0; prescaler p=0; digit index k=0.
- an, seg and dp driven to the inactive level (all 1s when ACTIVE_LOW=1); digit_idx=0; frame_tick=0.
- Reset asserted mid-scan or coincident with load: reset wins and the load is discarded.

Shadow registers:
- load=1 captures the inputs at that edge.
- The new values reach the outputs at the next output-register update (one cycle after capture).
- Load does not disturb p or k.
- Inputs are ignored when load=0.

Scan timing:
- p counts 0..SCAN_DIV-1, then wraps to 0.
- On wrap, k increments; it wraps from N_DIGITS-1 to 0.
- Digit k is "lit" while p < SCAN_DIV-BLANK_CYC.

Outputs (all registered, one cycle behind p/k/shadow):
- an[k] is active when lit; all other anodes are inactive.
- seg and dp are forced to inactive during the blanking window.
- digit_idx follows k, also delayed one cycle.
- frame_tick=1 for exactly one cycle, registered from the condition p==SCAN_DIV-1 && k==N_DIGITS-1.

Decode, active-high form (inverted when ACTIVE_LOW=1):

| Code | Glyph | seg (hex) |
|------|-------|-----------|
| 0 | 0 | 3F |
| 1 | 1 | 06 |
| 2 | 2 | 5B |
| 3 | 3 | 4F |
| 4 | 4 | 66 |
| 5 | 5 | 6D |
| 6 | 6 | 7D |
| 7 | 7 | 07 |
| 8 | 8 | 7F |
| 9 | 9 | 6F |
| 10 | A (HEX_MODE=1) | 77 |
| 11 | b (HEX_MODE=1) | 7C |
| 12 | C (HEX_MODE=1) | 39 |
| 13 | d (HEX_MODE=1) | 5E |
| 14 | E (HEX_MODE=1) | 79 |
| 15 | F (HEX_MODE=1) | 71 |

- Codes 10-15 with HEX_MODE=0 decode to 00 (blank).

Leading-zero blanking (shadow lz_en=1):
- Digit i (i>0) is blanked when it and every higher digit are 0.
- Digit 0 is never blanked.
- A blanked digit still drives its anode, but seg is inactive.
- dp is still shown if set.

Edge cases:
- N_DIGITS=1: k stays 0; frame_tick pulses every SCAN_DIV cycles.
- BLANK_CYC=0: no blanking window; the anode stays on for the full slot.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with load=1 and digits_in=16'h1234 (ACTIVE_LOW=1). Required: an=4'hF, seg=7'h7F, dp=1 throughout. After release, digits still read 0, i.e. seg=7'h40 when lit.
2. Scan order (N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1): load 16'h1234. Required per slot:
   - an cycles 4'hE,4'hD,4'hB,4'h7.
   - seg 7'h4F ('3'... i.e. digit0='4'→7'h19, digit1='3'→7'h30, digit2='2'→7'h24, digit3='1'→7'h79).
   - each anode active exactly 3 cycles followed by 1 all-off cycle.
   - frame_tick pulses once per 16 cycles.
3. Leading-zero blanking: load 16'h0070 with lz_en=1. Required: digits 3 and 2 show seg=7'h7F with their anodes active; digit1 shows 7'h78; digit0 shows 7'h40. Then load 16'h0000: only digit 0 shows 7'h40.
4. Hex mode: with HEX_MODE=1, load 16'hABCF. Required: glyphs F,C,b,A, i.e. 7'h0E,7'h46,7'h03,7'h08. With HEX_MODE=0, the same load gives seg=7'h7F on all four digits.
5. Mid-scan load: load a new value during digit 2's slot. Required: the new value appears on seg exactly 1 cycle after capture; an/digit_idx sequence unperturbed.
6. Decimal point and reset mid-frame: dp_in=4'b0100 lights dp (0) only in digit 2's slot, never in its blank cycle. Asserting rst_n=0 during slot 2 returns digit_idx=0 and all outputs inactive on the next edge.
